// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter between NUM_REQ requesters; times each frame locally.
// Optional macro UART_TX_ARB_FIXED_PRIO_EN: lowest asserted index always wins instead of round-robin.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned baudRate = 9600,
  parameter int unsigned clkFreq  = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_trigger,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int unsigned ID_W         = $clog2(NUM_REQ);
  localparam int unsigned P            = clkFreq / baudRate;
  localparam int unsigned FRAME_CYCLES = 10 * (P + 1) + 1;
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {HOLDOFF, IDLE, GRANT, FRAME} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    last_grant, last_nxt;
  logic [ID_W-1:0]    cand, win, gid_nxt;
  logic               found;
  logic [7:0]         win_data, data_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic               trig_nxt, busy_nxt;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      cand = ID_W'(i);
`else
      cand = ID_W'((32'(last_grant) + 1 + i) % NUM_REQ);
`endif
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) win_data = req_data[8*i +: 8];
    end
  end

  // Outputs are registered by decoding them from the next state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_grant;
    ack_nxt   = '0;
    trig_nxt  = 1'b0;
    data_nxt  = tx_data;
    gid_nxt   = grant_id;
    busy_nxt  = 1'b1;
    case (state)
      HOLDOFF: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      IDLE: begin
        busy_nxt = 1'b0;
        if (found) begin
          state_nxt    = GRANT;
          busy_nxt     = 1'b1;
          trig_nxt     = 1'b1;
          ack_nxt[win] = 1'b1;
          data_nxt     = win_data;
          gid_nxt      = win;
          last_nxt     = win;
        end
      end
      GRANT: begin
        state_nxt = FRAME;
        cnt_nxt   = FRAME_LOAD;
      end
      FRAME: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HOLDOFF;
      cnt        <= HOLD_LOAD;
      last_grant <= LAST_RST;
      req_ack    <= '0;
      tx_trigger <= 1'b0;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_nxt;
      req_ack    <= ack_nxt;
      tx_trigger <= trig_nxt;
      tx_data    <= data_nxt;
      grant_id   <= gid_nxt;
      busy       <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-based reference model, behavioural transmitter/receiver and directed + random stimulus.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int FC = 111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic [3:0] req_ack;
  logic [7:0] tx_data;
  logic       tx_trigger;
  logic [1:0] grant_id;
  logic       busy;
  logic [7:0] byte_q [NR];

  assign req_data = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};

  uart_tx_arbiter #(.NUM_REQ(4), .baudRate(1_000_000), .clkFreq(10_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_data(tx_data), .tx_trigger(tx_trigger),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, idle_from, rr_last;
  logic       exp_trig, exp_busy;
  logic [3:0] exp_ack;
  logic [7:0] exp_data;
  logic [1:0] exp_gid;
  logic [3:0] drop_on_ack;
  int         trig_cyc[$];
  int         trig_id[$];
  logic [7:0] trig_data[$];
  logic [3:0] trig_ack[$];
  logic [7:0] rx_q[$];
  logic [9:0] tx_shift, rx_bits;
  int         tx_left, rx_t;
  bit         rx_act;
  logic       line;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  int rr_ids[5]  = '{0, 0, 0, 0, 0};
  int rst_ids[3] = '{0, 0, 0};
`else
  int rr_ids[5]  = '{0, 1, 2, 3, 0};
  int rst_ids[3] = '{0, 1, 2};
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs();
    chk("busy", busy, exp_busy);
    chk("tx_trigger", tx_trigger, exp_trig);
    chk("req_ack", req_ack, exp_ack);
    chk("tx_data", tx_data, exp_data);
    chk("grant_id", grant_id, exp_gid);
  endtask

  task automatic set_reset_exp();
    exp_busy = 1'b1; exp_trig = 1'b0; exp_ack = '0; exp_data = 8'h00; exp_gid = '0;
  endtask

  // Transmitter has no reset: it keeps shifting across arbiter resets. Receiver samples mid-bit.
  task automatic line_step();
    if (tx_left > 0) begin
      line = tx_shift[(FC - 1 - tx_left) / 11];
      tx_left--;
    end else begin
      line = 1'b1;
    end
    if (tx_trigger) begin
      chk("tx_overlap", tx_left, 0);
      tx_shift = {1'b1, tx_data, 1'b0};
      tx_left  = FC - 1;
    end
    if (!rx_act && line == 1'b0) begin
      rx_act = 1'b1;
      rx_t   = 0;
    end
    if (rx_act) begin
      if (rx_t % 11 == 5) rx_bits[rx_t / 11] = line;
      if (rx_t == 104) begin
        chk("rx_start_bit", rx_bits[0], 0);
        chk("rx_stop_bit", rx_bits[9], 1);
        rx_q.push_back(rx_bits[8:1]);
        rx_act = 1'b0;
      end else begin
        rx_t++;
      end
    end
  endtask

  task automatic tick();
    int w;
    w = 0;
    if (cyc >= idle_from && req_valid != 4'b0) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      for (int k = NR - 1; k >= 0; k--) if (req_valid[k]) w = k;
`else
      for (int k = NR; k >= 1; k--) if (req_valid[(rr_last + k) % NR]) w = (rr_last + k) % NR;
`endif
      exp_trig  = 1'b1;
      exp_ack   = 4'(1 << w);
      exp_data  = byte_q[w];
      exp_gid   = 2'(w);
      exp_busy  = 1'b1;
      rr_last   = w;
      idle_from = cyc + FC + 1;
    end else begin
      exp_trig = 1'b0;
      exp_ack  = '0;
      exp_busy = (cyc + 1 < idle_from);
    end
    @(posedge clk); #1;
    cyc++;
    chk_outputs();
    if (tx_trigger) begin
      trig_cyc.push_back(cyc);
      trig_id.push_back(int'(grant_id));
      trig_data.push_back(tx_data);
      trig_ack.push_back(req_ack);
    end
    line_step();
    for (int i = 0; i < NR; i++) if (req_ack[i] && drop_on_ack[i]) req_valid[i] = 1'b0;
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    cyc = 0; idle_from = FC; rr_last = NR - 1;
    set_reset_exp();
    trig_cyc.delete(); trig_id.delete(); trig_data.delete(); trig_ack.delete();
    chk_outputs();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    set_reset_exp();
    chk_outputs();
    repeat (2) begin
      @(posedge clk); #1;
      line_step();
      chk_outputs();
    end
    release_rst();
  endtask

  task automatic wait_trigs(input int n, input int budget);
    int b;
    b = 0;
    while (trig_cyc.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (trig_cyc.size() < n) chk("trig_timeout", trig_cyc.size(), n);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; drop_on_ack = '1;
    tx_left = 0; rx_act = 1'b0; rx_t = 0; rx_bits = '0; line = 1'b1; tx_shift = '1;
    for (int i = 0; i < NR; i++) byte_q[i] = 8'h00;
    cyc = 0; idle_from = FC; rr_last = NR - 1;
    set_reset_exp();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs();

    // Reset holdoff: first trigger lands at cycle 112.
    req_valid = 4'b0001; byte_q[0] = 8'h5A;
    release_rst();
    wait_trigs(1, 200);
    if (trig_cyc.size() >= 1) begin
      chk("hold_first_trig_cyc", trig_cyc[0], 112);
      chk("hold_first_data", trig_data[0], 8'h5A);
      chk("hold_first_ack", trig_ack[0], 4'b0001);
    end

    // All four persistent: order and 112-cycle spacing.
    req_valid = 4'b1111; drop_on_ack = '0;
    for (int i = 0; i < NR; i++) byte_q[i] = 8'hA0 + 8'(i);
    reset_pulse();
    wait_trigs(5, 700);
    if (trig_cyc.size() >= 5) begin
      chk("rr_first_cyc", trig_cyc[0], 112);
      for (int k = 0; k < 5; k++) begin
        chk("rr_id", trig_id[k], rr_ids[k]);
        chk("rr_data", trig_data[k], 8'hA0 + 8'(rr_ids[k]));
        if (k > 0) chk("rr_spacing", trig_cyc[k] - trig_cyc[k-1], 112);
      end
    end

    // Wrap and skip after a grant to requester 2.
    req_valid = 4'b0100; drop_on_ack = '1; byte_q[2] = 8'h22;
    reset_pulse();
    wait_trigs(1, 200);
    req_valid = 4'b0011; byte_q[0] = 8'h10; byte_q[1] = 8'h11;
    wait_trigs(3, 400);
    if (trig_cyc.size() >= 3) begin
      chk("wrap_id0", trig_id[0], 2);
      chk("wrap_id1", trig_id[1], 0);
      chk("wrap_id2", trig_id[2], 1);
      chk("wrap_data2", trig_data[2], 8'h11);
    end

    // Withdrawal during FRAME: nothing sent afterwards.
    req_valid[2] = 1'b1; byte_q[2] = 8'h77;
    repeat (20) tick();
    req_valid[2] = 1'b0;
    repeat (250) tick();
    chk("withdraw_trig_count", trig_cyc.size(), 3);

    // Two bytes through the serial transmitter model.
    rx_q.delete();
    byte_q[0] = 8'h55; byte_q[1] = 8'hC3; req_valid = 4'b0011;
    wait_trigs(5, 400);
    repeat (130) tick();
    chk("rx_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("rx_byte0", rx_q[0], 8'h55);
      chk("rx_byte1", rx_q[1], 8'hC3);
    end

    // Async reset with the frame counter at 50.
    drop_on_ack = '0; req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) byte_q[i] = 8'hA0 + 8'(i);
    wait_trigs(6, 300);
    repeat (60) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_grant_id", grant_id, 2'd0);
    set_reset_exp();
    repeat (2) begin
      @(posedge clk); #1;
      line_step();
      chk_outputs();
    end
    release_rst();
    wait_trigs(3, 500);
    if (trig_cyc.size() >= 3) begin
      chk("midrst_first_cyc", trig_cyc[0], 112);
      for (int k = 0; k < 3; k++) chk("midrst_id", trig_id[k], rst_ids[k]);
    end

    // Random traffic with withdrawals.
    req_valid = '0; drop_on_ack = '1;
    reset_pulse();
    repeat (3000) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < 4) begin
            byte_q[i]    = 8'($urandom);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 999) < 3) begin
          req_valid[i] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
